// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives a 1-cycle-latency instruction memory
// and presents {pc, pc+4, instr, valid} to the IF/ID stage register.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] out_pc,
    output logic [31:0] out_pc_plus4,
    output logic [31:0] out_instr,
    output logic        out_valid,
    output logic        flush_ifid
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t      state_r, state_nxt_s;
    logic [31:0] pc_r, pc_nxt_s;
    logic [31:0] resp_pc_r, resp_pc_nxt_s;
    logic [31:0] hold_r, hold_nxt_s;
    logic [31:0] redir_tgt_s;
    logic        valid_s;

    assign redir_tgt_s = {redirect_pc[31:2], 2'b00};

    // Next-state and next-register selection; redirect overrides stall in every state.
    always_comb begin
        state_nxt_s   = state_r;
        pc_nxt_s      = pc_r;
        resp_pc_nxt_s = resp_pc_r;
        hold_nxt_s    = hold_r;
        if (redirect_valid) begin
            pc_nxt_s      = redir_tgt_s + 32'd4;
            resp_pc_nxt_s = redir_tgt_s;
            state_nxt_s   = FETCH;
        end else begin
            case (state_r)
                BOOT: begin
                    pc_nxt_s      = pc_r + 32'd4;
                    resp_pc_nxt_s = pc_r;
                    state_nxt_s   = FETCH;
                end
                FETCH: begin
                    if (stall) begin
                        // Capture the response now; memory will return pc_r's data next cycle.
                        hold_nxt_s  = imem_rdata;
                        state_nxt_s = HOLD;
                    end else begin
                        pc_nxt_s      = pc_r + 32'd4;
                        resp_pc_nxt_s = pc_r;
                        state_nxt_s   = FETCH;
                    end
                end
                HOLD: begin
                    if (stall) begin
                        state_nxt_s = HOLD;
                    end else begin
                        pc_nxt_s      = pc_r + 32'd4;
                        resp_pc_nxt_s = pc_r;
                        state_nxt_s   = FETCH;
                    end
                end
                default: begin
                    state_nxt_s = BOOT;
                end
            endcase
        end
    end

    // State and PC registers with synchronous reset.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_r   <= BOOT;
            pc_r      <= RESET_PC;
            resp_pc_r <= 32'h0000_0000;
            hold_r    <= NOP_INSTR;
        end else begin
            state_r   <= state_nxt_s;
            pc_r      <= pc_nxt_s;
            resp_pc_r <= resp_pc_nxt_s;
            hold_r    <= hold_nxt_s;
        end
    end

    // Output decode; invalid slots present a clean NOP with zeroed PCs.
    always_comb begin
        valid_s      = (state_r != BOOT) && !redirect_valid;
        imem_addr    = redirect_valid ? redir_tgt_s : pc_r;
        flush_ifid   = redirect_valid;
        out_valid    = valid_s;
        out_pc       = 32'h0000_0000;
        out_pc_plus4 = 32'h0000_0000;
        out_instr    = NOP_INSTR;
        if (valid_s) begin
            out_pc       = resp_pc_r;
            out_pc_plus4 = resp_pc_r + 32'd4;
            out_instr    = (state_r == HOLD) ? hold_r : imem_rdata;
        end else begin
            out_pc       = 32'h0000_0000;
            out_pc_plus4 = 32'h0000_0000;
            out_instr    = NOP_INSTR;
        end
    end

endmodule
